// File: rtl/ir_xmit_pkg.sv
// Shared NEC protocol constants and transmitter state encoding.
package ir_xmit_pkg;

  localparam int unsigned NecLeadMarkU  = 16;
  localparam int unsigned NecLeadSpaceU = 8;
  localparam int unsigned NecRptSpaceU  = 4;
  localparam int unsigned NecBit1SpaceU = 3;
  localparam int unsigned NecBit0SpaceU = 1;
  localparam int unsigned NecFrameU     = 192;
  localparam int unsigned NecBits       = 32;

  typedef enum logic [3:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap,
    StRptMark,
    StRptSpace,
    StRptStop
  } nec_state_e;

  function automatic logic is_mark(nec_state_e s);
    return s inside {StLeadMark, StBitMark, StStopMark, StRptMark, StRptStop};
  endfunction

endpackage

// File: rtl/ir_nec_timebase.sv
// NEC unit timebase (unit_tick every UnitCyc cycles) plus carrier toggler.
module ir_nec_timebase #(
  parameter int unsigned UnitCyc  = 15188,
  parameter int unsigned CarrHalf = 355
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic carr_restart_i,
  output logic unit_tick_o,
  output logic carrier_o
);

  localparam int unsigned SubW  = (UnitCyc > 1) ? $clog2(UnitCyc) : 1;
  localparam int unsigned CarrW = (CarrHalf > 1) ? $clog2(CarrHalf) : 1;

  logic [SubW-1:0]  sub_q, sub_d;
  logic [CarrW-1:0] carr_cnt_q, carr_cnt_d;
  logic             carrier_q, carrier_d;

  assign unit_tick_o = (sub_q == SubW'(UnitCyc - 1));
  assign carrier_o   = carrier_q;

  always_comb begin
    sub_d = sub_q + SubW'(1);
    if (restart_i || unit_tick_o) begin
      sub_d = '0;
    end
  end

  // Forcing phase 1 at a mark start keeps the first carrier pulse full width.
  always_comb begin
    carr_cnt_d = carr_cnt_q + CarrW'(1);
    carrier_d  = carrier_q;
    if (carr_restart_i) begin
      carr_cnt_d = '0;
      carrier_d  = 1'b1;
    end else if (carr_cnt_q == CarrW'(CarrHalf - 1)) begin
      carr_cnt_d = '0;
      carrier_d  = ~carrier_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q      <= '0;
      carr_cnt_q <= '0;
      carrier_q  <= 1'b0;
    end else begin
      sub_q      <= sub_d;
      carr_cnt_q <= carr_cnt_d;
      carrier_q  <= carrier_d;
    end
  end

endmodule

// File: rtl/ir_xmit.sv
// NEC IR transmitter: leader, 32 data bits, stop mark, then repeat frames while tx_repeat is held.
module ir_xmit
  import ir_xmit_pkg::*;
#(
  parameter int unsigned UNIT_CYC    = 15188,
  parameter int unsigned CARR_HALF   = 355,
  parameter int unsigned FRAME_UNITS = 192
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        tx_req,
  input  logic [15:0] tx_code,
  input  logic        tx_repeat,
  output logic        tx_ack,
  output logic        tx_busy,
  output logic        ir_tx_n,
  output logic        ir_tx_mod,
  output logic [7:0]  frame_cnt
);

  nec_state_e  state_q, state_d;
  logic [4:0]  dur_q, dur_d;
  logic [7:0]  unit_q, unit_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  frame_q, frame_d;
  logic        ack_q, ack_d;
  logic        unit_tick, carrier, restart, carr_restart, done;
  logic [4:0]  len;

  ir_nec_timebase #(
    .UnitCyc  (UNIT_CYC),
    .CarrHalf (CARR_HALF)
  ) u_timebase (
    .clk_i          (clk27),
    .rst_ni         (reset_n),
    .restart_i      (restart),
    .carr_restart_i (carr_restart),
    .unit_tick_o    (unit_tick),
    .carrier_o      (carrier)
  );

  always_comb begin
    unique case (state_q)
      StLeadMark, StRptMark: len = 5'(NecLeadMarkU);
      StLeadSpace:           len = 5'(NecLeadSpaceU);
      StRptSpace:            len = 5'(NecRptSpaceU);
      StBitSpace:            len = shreg_q[0] ? 5'(NecBit1SpaceU) : 5'(NecBit0SpaceU);
      default:               len = 5'd1;
    endcase
  end

  assign done = unit_tick && (dur_q == len - 5'd1);

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    unit_d    = unit_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    ack_d     = 1'b0;
    restart   = 1'b0;
    if (unit_tick) begin
      dur_d  = dur_q + 5'd1;
      unit_d = unit_q + 8'd1;
    end
    unique case (state_q)
      StIdle: begin
        restart = 1'b1;
        unit_d  = '0;
        if (tx_req) begin
          state_d   = StLeadMark;
          ack_d     = 1'b1;
          shreg_d   = {~tx_code[7:0], tx_code[7:0], ~tx_code[15:8], tx_code[15:8]};
          bit_cnt_d = '0;
        end
      end
      StLeadMark:  if (done) state_d = StLeadSpace;
      StLeadSpace: if (done) state_d = StBitMark;
      StBitMark:   if (done) state_d = StBitSpace;
      StBitSpace: begin
        if (done) begin
          shreg_d   = {1'b0, shreg_q[31:1]};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(NecBits - 1)) ? StStopMark : StBitMark;
        end
      end
      StStopMark, StRptStop: begin
        if (done) begin
          state_d = StGap;
          frame_d = frame_q + 8'd1;
        end
      end
      StGap: begin
        // Frame boundary: the next frame's timebase starts cleanly from zero.
        if (unit_tick && unit_q == 8'(FRAME_UNITS - 1)) begin
          restart = 1'b1;
          unit_d  = '0;
          state_d = tx_repeat ? StRptMark : StIdle;
        end
      end
      StRptMark:  if (done) state_d = StRptSpace;
      StRptSpace: if (done) state_d = StRptStop;
      default:    state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      dur_d = '0;
    end
  end

  assign carr_restart = is_mark(state_d) && !is_mark(state_q);

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      dur_q     <= '0;
      unit_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      unit_q    <= unit_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      ack_q     <= ack_d;
    end
  end

  assign tx_ack    = ack_q;
  assign tx_busy   = (state_q != StIdle);
  assign ir_tx_n   = ~is_mark(state_q);
  assign ir_tx_mod = is_mark(state_q) & carrier;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_ir_xmit.sv
// Bench for ir_xmit: segment-level NEC frame model, table of transfers, reset and req corner cases.
module tb_ir_xmit;

  localparam int Unit      = 8;
  localparam int CarrHalf  = 2;
  localparam int FrameU    = 192;
  localparam int FrameCyc  = FrameU * Unit;

  logic        clk27 = 1'b0;
  logic        reset_n;
  logic        tx_req;
  logic [15:0] tx_code;
  logic        tx_repeat;
  logic        tx_ack;
  logic        tx_busy;
  logic        ir_tx_n;
  logic        ir_tx_mod;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  int model_fc = 0;
  bit exp_lv [0:FrameCyc-1];

  typedef struct {
    logic [15:0] code;
    int          nrep;
    bit          req_at_end;
    int          exp_frames;
  } vec_t;

  vec_t tbl [5];

  ir_xmit #(
    .UNIT_CYC    (Unit),
    .CARR_HALF   (CarrHalf),
    .FRAME_UNITS (FrameU)
  ) dut (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .tx_req    (tx_req),
    .tx_code   (tx_code),
    .tx_repeat (tx_repeat),
    .tx_ack    (tx_ack),
    .tx_busy   (tx_busy),
    .ir_tx_n   (ir_tx_n),
    .ir_tx_mod (ir_tx_mod),
    .frame_cnt (frame_cnt)
  );

  always #5 clk27 = ~clk27;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic mark(input int start_u, input int len_u);
    for (int c = start_u * Unit; c < (start_u + len_u) * Unit; c++) exp_lv[c] = 1'b0;
  endtask

  function automatic logic [31:0] data_word(input logic [15:0] code);
    return {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
  endfunction

  // Expected demodulated level per cycle of one frame, built from NEC segment durations.
  task automatic build_frame(input logic [15:0] code, input bit rpt);
    int u;
    logic [31:0] w;
    for (int i = 0; i < FrameCyc; i++) exp_lv[i] = 1'b1;
    mark(0, 16);
    if (rpt) begin
      mark(20, 1);
    end else begin
      w = data_word(code);
      u = 24;
      for (int b = 0; b < 32; b++) begin
        mark(u, 1);
        u += 1 + (w[b] ? 3 : 1);
      end
      mark(u, 1);
    end
  endtask

  task automatic send(input logic [15:0] code, input int nrep, input bit req_at_end,
                      input int exp_frames);
    int len = (1 + nrep) * FrameCyc;
    int e_lv = 0, e_mod = 0, e_busy = 0, e_ack = 0, e_fc = 0;
    int ms = 0, c, j, fc0;
    bit exp_mod;
    fc0 = model_fc;
    tx_code = code;
    tx_req  = 1'b1;
    @(negedge clk27);
    tx_req = 1'b0;
    for (int k = 0; k < len; k++) begin
      j = k / FrameCyc;
      c = k % FrameCyc;
      if (c == 0) begin
        build_frame(code, j > 0);
        if (frame_cnt !== 8'(fc0 + j)) e_fc++;
      end
      if (!exp_lv[c] && (c == 0 || exp_lv[c-1])) ms = c;
      exp_mod = !exp_lv[c] && (((c - ms) / CarrHalf) % 2 == 0);
      if (ir_tx_n !== exp_lv[c]) begin
        if (e_lv == 0) $display("note: first ir_tx_n deviation at cycle %0d", k);
        e_lv++;
      end
      if (ir_tx_mod !== exp_mod) e_mod++;
      if (tx_busy !== 1'b1) e_busy++;
      if (tx_ack !== (k == 0)) e_ack++;
      tx_repeat = (c == FrameCyc - 1) ? (j < nrep) : 1'($urandom % 2);
      tx_req    = (k == len - 1) ? req_at_end : ($urandom % 8 == 0);
      tx_code   = 16'($urandom);
      @(negedge clk27);
    end
    model_fc = (fc0 + exp_frames) % 256;
    check("wave_errs", e_lv, 0);
    check("mod_errs", e_mod, 0);
    check("busy_errs", e_busy, 0);
    check("ack_errs", e_ack, 0);
    check("fcnt_mid_errs", e_fc, 0);
    check("fcnt_end", frame_cnt, model_fc);
    check("busy_idle", tx_busy, 0);
    check("ack_idle", tx_ack, 0);
    check("line_idle", ir_tx_n, 1);
    tx_repeat = 1'b0;
    if (!req_at_end) tx_req = 1'b0;
  endtask

  initial begin
    int u, n;
    logic [31:0] w;
    reset_n   = 1'b0;
    tx_req    = 1'b0;
    tx_code   = '0;
    tx_repeat = 1'b0;
    tbl[0] = '{16'h00FF, 0, 1'b0, 1};
    tbl[1] = '{16'h1A2B, 2, 1'b1, 3};
    tbl[2] = '{16'($urandom), 0, 1'b0, 1};
    tbl[3] = '{16'hFFFF, 1, 1'b0, 2};
    tbl[4] = '{16'h0000, 0, 1'b0, 1};

    #1;
    check("rst_ack", tx_ack, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_line", ir_tx_n, 1);
    check("rst_mod", ir_tx_mod, 0);
    check("rst_fcnt", frame_cnt, 0);
    repeat (3) @(negedge clk27);
    reset_n = 1'b1;
    @(negedge clk27);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].code, tbl[i].nrep, tbl[i].req_at_end, tbl[i].exp_frames);
    end

    // Abort inside bit 17's mark with an asynchronous reset.
    tx_code = 16'h5AC3;
    tx_req  = 1'b1;
    @(negedge clk27);
    tx_req = 1'b0;
    w = data_word(16'h5AC3);
    u = 24;
    for (int b = 0; b < 17; b++) u += 1 + (w[b] ? 3 : 1);
    n = u * Unit + 3;
    repeat (n) @(negedge clk27);
    check("pre_rst_mark", ir_tx_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_line", ir_tx_n, 1);
    check("arst_mod", ir_tx_mod, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_fcnt", frame_cnt, 0);
    @(negedge clk27);
    reset_n  = 1'b1;
    model_fc = 0;
    @(negedge clk27);
    send(16'hC33C, 0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
